io_input_queue: RTL and testbench

Producer side of the input path consumed by the DMA's read-input instructions (RAI, RI, GIA, PAUSE). It debounces the board apply pushbutton and, on each accepted press, captures the 22-bit switch word into a 32-deep show-ahead FIFO. The DMA pops entries with a one-cycle strobe and reads the pending-entry count directly. All logic runs in the single `clock` domain.

---
 rtl/io_input_queue.sv | 211 +++++++++++++++++++++
 tb/tb_io_input_queue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// io_input_queue
//
// Producer side of the DMA input path. The raw apply pushbutton is
// synchronized and turned into a single push per press. Each push captures the
// switch word into a show-ahead FIFO that the DMA drains with one-cycle pops.
//
// Build option:
//   IO_INPUT_DEBOUNCE_EN  defined     -> four-state debounce FSM, a press must
//                                        hold DEBOUNCE_CYCLES cycles
//                         not defined -> every synchronized falling edge pushes
//
// Ports:
//   clock          sole clock, rising edge
//   init_flag      asynchronous active-low reset
//   apply_btn      raw pushbutton, low = pressed, asynchronous to clock
//   io_in          switch word captured on each push
//   rd_req         pop strobe, one pop per cycle while high and not empty
//   rd_data        registered head entry, valid while rd_valid
//   rd_valid       FIFO not empty
//   full           FIFO holds 2^DEPTH_LOG2 entries
//   inputs_amount  pending entry count, zero-extended
//   overflow_cnt   presses dropped while full, saturating at 255
// -----------------------------------------------------------------------------
module io_input_queue #(
  parameter int unsigned DEPTH_LOG2      = 5,
  parameter int unsigned WIDTH           = 22,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             init_flag,
  input  logic             apply_btn,
  input  logic [WIDTH-1:0] io_in,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic [15:0]      inputs_amount,
  output logic [7:0]       overflow_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("io_input_queue: DEBOUNCE_CYCLES must be within 2..65535");
  end

  // ---- button synchronizer (resets to the released level) ----
  logic sync1_q;
  logic btn_s_q;
  logic push;

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      sync1_q <= 1'b1;
      btn_s_q <= 1'b1;
    end else begin
      sync1_q <= apply_btn;
      btn_s_q <= sync1_q;
    end
  end

  // ---- press detection ----
`ifdef IO_INPUT_DEBOUNCE_EN
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  // The wait states compare the incremented count, so a level change is
  // accepted after DEBOUNCE_CYCLES consecutive samples including the one
  // that left IDLE/HELD.
  localparam logic [15:0] DCNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  db_state_e   state_q, state_d;
  logic [15:0] dcnt_q, dcnt_d, dcnt_inc;

  assign dcnt_inc = dcnt_q + 16'd1;

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!btn_s_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (btn_s_q) begin
          state_d = IDLE;
        end else if (dcnt_inc == DCNT_LAST) begin
          state_d = HELD;
          push    = 1'b1;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      HELD: begin
        if (btn_s_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s_q) begin
          state_d = HELD;
        end else if (dcnt_inc == DCNT_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  // Without debounce every synchronized 1->0 transition is a press.
  logic btn_prev_q;

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      btn_prev_q <= 1'b1;
    end else begin
      btn_prev_q <= btn_s_q;
    end
  end

  assign push = btn_prev_q & ~btn_s_q;
`endif

  // ---- FIFO pointers, occupancy and overflow ----
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             empty, is_full, pop, wr_en;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign is_full = (count == PW'(DEPTH));
  assign pop     = rd_req & ~empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign wr_en   = push & (~is_full | pop);

  assign wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};

  always_comb begin
    ovf_d = ovf_q;
    if (push && is_full && !pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // The head register looks ahead at the next read pointer; when that slot
  // is being written this very edge, the incoming word is forwarded.
  always_comb begin
    rd_data_d = mem[rd_ptr_d[DEPTH_LOG2-1:0]];
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = io_in;
    end
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is left uncleared by reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= io_in;
    end
  end

  // ---- outputs ----
  assign rd_data       = rd_data_q;
  assign rd_valid      = ~empty;
  assign full          = is_full;
  assign inputs_amount = 16'(count);
  assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_io_input_queue.sv
`timescale 1ns/1ps
module tb_io_input_queue;

  localparam int DB    = 4;
  localparam int W     = 22;
  localparam int DEPTH = 32;
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int PUSH_LAT = DB + 2;
  localparam bit DEB      = 1'b1;
`else
  localparam int PUSH_LAT = 3;
  localparam bit DEB      = 1'b0;
`endif

  logic         clock     = 1'b0;
  logic         init_flag = 1'b0;
  logic         apply_btn = 1'b1;
  logic         rd_req    = 1'b0;
  logic [W-1:0] io_in     = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         full;
  logic [15:0]  inputs_amount;
  logic [7:0]   overflow_cnt;

  int checks = 0;
  int errors = 0;
  bit sb_en  = 1'b0;

  io_input_queue #(
    .DEPTH_LOG2     (5),
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock        (clock),
    .init_flag    (init_flag),
    .apply_btn    (apply_btn),
    .io_in        (io_in),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .inputs_amount(inputs_amount),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of pending words, button seen through a two-sample delay line.
  logic [W-1:0] mq[$];
  int           m_ovf;
  logic         m_s1, m_s2;
  bit           m_push, m_pop;
`ifdef IO_INPUT_DEBOUNCE_EN
  logic         m_acc;   // last accepted button level
  int           m_run;   // consecutive samples differing from m_acc
`else
  logic         m_prev;
`endif

  initial begin
    forever begin
      @(posedge clock or negedge init_flag);
      if (!init_flag) begin
        mq.delete();
        m_ovf = 0;
        m_s1  = 1'b1;
        m_s2  = 1'b1;
`ifdef IO_INPUT_DEBOUNCE_EN
        m_acc = 1'b1;
        m_run = 0;
`else
        m_prev = 1'b1;
`endif
      end else begin
        m_push = 1'b0;
`ifdef IO_INPUT_DEBOUNCE_EN
        if (m_s2 != m_acc) begin
          m_run++;
          if (m_run == DB) begin
            m_acc  = m_s2;
            m_run  = 0;
            m_push = !m_acc;
          end
        end else begin
          m_run = 0;
        end
`else
        m_push = m_prev && !m_s2;
        m_prev = m_s2;
`endif
        m_pop = rd_req && (mq.size() > 0);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (mq.size() < DEPTH) mq.push_back(io_in);
          else if (m_ovf < 255) m_ovf++;
        end
        m_s2 = m_s1;
        m_s1 = apply_btn;
      end
    end
  end

  // Scoreboard compare on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (sb_en && init_flag) begin
        check("sb_amount", inputs_amount, mq.size());
        check("sb_valid", rd_valid, mq.size() > 0);
        check("sb_full", full, mq.size() == DEPTH);
        check("sb_ovf", overflow_cnt, m_ovf);
        if (mq.size() > 0) check("sb_data", rd_data, mq[0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic press(input logic [W-1:0] w);
    io_in     = w;
    apply_btn = 1'b0;
    step(DB + 3);
    apply_btn = 1'b1;
    step(DB + 3);
  endtask

  task automatic pops(input int n);
    rd_req = 1'b1;
    step(n);
    rd_req = 1'b0;
  endtask

  typedef struct {
    int presses;
    int npops;
    int exp_amt;
    bit exp_full;
    int exp_ovf;
  } vec_t;

  vec_t         vecs[5];
  int           word;
  int           hold;
  logic [W-1:0] wsim;

  initial begin
    vecs[0] = '{1, 0, 1, 1'b0, 0};
    vecs[1] = '{3, 0, 4, 1'b0, 0};
    vecs[2] = '{0, 2, 2, 1'b0, 0};
    vecs[3] = '{0, 5, 0, 1'b0, 0};
    vecs[4] = '{2, 1, 1, 1'b0, 0};

    // Reset state
    step(2);
    check("rst_amount", inputs_amount, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow_cnt, 0);
    check("rst_data", rd_data, 0);
    init_flag = 1'b1;
    step(1);
    sb_en = 1'b1;

    // Single press with exact latency
    io_in     = 22'h2A5A5;
    apply_btn = 1'b0;
    step(PUSH_LAT - 1);
    check("press_before", inputs_amount, 0);
    step(1);
    check("press_amount", inputs_amount, 1);
    check("press_valid", rd_valid, 1);
    check("press_data", rd_data, 22'h2A5A5);
    step(20 - PUSH_LAT);
    apply_btn = 1'b1;
    step(DB + 3);
    check("hold_norepeat", inputs_amount, 1);
    pops(1);
    check("pop_amount", inputs_amount, 0);
    check("pop_valid", rd_valid, 0);

    // Bounce rejection
    io_in = 22'h155;
    for (int i = 0; i < 5; i++) begin
      apply_btn = 1'b0;
      step(2);
      apply_btn = 1'b1;
      step(2);
    end
    apply_btn = 1'b0;
    step(10);
    apply_btn = 1'b1;
    step(DB + 3);
    check("bounce_pushes", inputs_amount, DEB ? 1 : 6);
    pops(8);
    check("bounce_drain", inputs_amount, 0);

    // Three fast edges within six cycles
    for (int i = 0; i < 3; i++) begin
      apply_btn = 1'b0;
      step(1);
      apply_btn = 1'b1;
      step(1);
    end
    step(DB + 3);
    check("fast_edges", inputs_amount, DEB ? 0 : 3);
    pops(4);

    // Table-driven press/pop sequence
    word = 100;
    foreach (vecs[i]) begin
      for (int p = 0; p < vecs[i].presses; p++) begin
        press(W'(word));
        word++;
      end
      if (vecs[i].npops > 0) pops(vecs[i].npops);
      check("tbl_amount", inputs_amount, vecs[i].exp_amt);
      check("tbl_full", full, vecs[i].exp_full);
      check("tbl_valid", rd_valid, vecs[i].exp_amt != 0);
      check("tbl_ovf", overflow_cnt, vecs[i].exp_ovf);
    end
    pops(2);

    // Fill and overflow, then in-order drain
    for (int i = 1; i <= 33; i++) press(W'(i));
    check("fill_full", full, 1);
    check("fill_amount", inputs_amount, 32);
    check("fill_ovf", overflow_cnt, 1);
    for (int i = 1; i <= 32; i++) begin
      check("drain_order", rd_data, i);
      pops(1);
    end
    check("drain_amount", inputs_amount, 0);
    check("drain_valid", rd_valid, 0);
    check("drain_full", full, 0);

    // Simultaneous push and pop while full
    for (int i = 1; i <= 32; i++) press(W'(200 + i));
    io_in     = 22'h3ABCD;
    apply_btn = 1'b0;
    step(PUSH_LAT - 1);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    check("pushpop_amount", inputs_amount, 32);
    check("pushpop_full", full, 1);
    check("pushpop_ovf", overflow_cnt, 1);
    step(DB + 3 - PUSH_LAT);
    apply_btn = 1'b1;
    step(DB + 3);
    pops(31);
    check("pushpop_tail", rd_data, 22'h3ABCD);
    check("pushpop_left", inputs_amount, 1);
    pops(1);

    // Overflow counter saturation
    for (int i = 0; i < 32 + 256; i++) press(W'(i));
    check("ovf_sat", overflow_cnt, 255);
    check("ovf_full", full, 1);
    pops(33);

    // Asynchronous reset in the middle of a press
    for (int i = 0; i < 3; i++) press(W'(300 + i));
    io_in     = 22'h777;
    apply_btn = 1'b0;
    step(3);
    check("prereset_amount", inputs_amount, DEB ? 3 : 4);
    #1;
    init_flag = 1'b0;
    #1;
    check("arst_amount", inputs_amount, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_full", full, 0);
    check("arst_ovf", overflow_cnt, 0);
    check("arst_data", rd_data, 0);
    apply_btn = 1'b1;
    step(2);
    init_flag = 1'b1;
    step(2 * DB + 8);
    check("post_rst_quiet", inputs_amount, 0);
    press(22'h55);
    check("post_rst_press", inputs_amount, 1);
    check("post_rst_data", rd_data, 22'h55);

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        apply_btn = ~apply_btn;
        hold = $urandom_range(1, 2 * DB + 3);
      end
      hold--;
      wsim   = W'($urandom);
      io_in  = wsim;
      rd_req = ($urandom_range(0, 5) == 0);
      step(1);
    end
    rd_req    = 1'b0;
    apply_btn = 1'b1;
    step(DB + 4);
    sb_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
